// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common-data-bus arbiter for the Tomasulo core. Buffers one
//                completed result per functional unit and grants the single
//                CDB to one buffer per cycle. The granted result is driven on
//                registered broadcast outputs.
//                Optional macro CDB_FIXED_PRIO_EN: when defined, the lowest
//                index full buffer always wins and no rotating pointer exists.
//                When undefined, arbitration is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int               N_REQ       = 4,
    parameter int               TAG_W       = 5,
    parameter int               DATA_W      = 32,
    parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*TAG_W-1:0]  in_tag,
    input  logic [N_REQ*DATA_W-1:0] in_val,
    output logic [N_REQ-1:0]        out_ready,
    output logic                    out_CDB_broadcast,
    output logic [TAG_W-1:0]        out_CDB_tag,
    output logic [DATA_W-1:0]       out_CDB_val,
    output logic [N_REQ-1:0]        out_pending
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   r_full;
    logic [TAG_W-1:0]   r_tag [N_REQ];
    logic [DATA_W-1:0]  r_val [N_REQ];

    logic               r_cdb_bcast;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_val;

    logic [N_REQ-1:0]   w_grant;
    logic               w_any_grant;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic [N_REQ-1:0]   w_load;
    logic [TAG_W-1:0]   w_in_tag [N_REQ];
    logic [DATA_W-1:0]  w_in_val [N_REQ];

`ifndef CDB_FIXED_PRIO_EN
    logic [c_IDX_W-1:0] r_ptr;
`endif

    // Grant selection looks only at buffer occupancy (and the pointer), never
    // at in_valid, so ready cannot combinationally depend on valid.
    always_comb begin
        w_any_grant = 1'b0;
        w_grant_idx = '0;
`ifdef CDB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any_grant && r_full[i]) begin
                w_any_grant = 1'b1;
                w_grant_idx = c_IDX_W'(i);
            end
        end
`else
        // Scan offsets 0..N_REQ-1 from the pointer; first full buffer wins.
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_any_grant && r_full[i] &&
                    (((int'(r_ptr) + k) % N_REQ) == i)) begin
                    w_any_grant = 1'b1;
                    w_grant_idx = c_IDX_W'(i);
                end
            end
        end
`endif
    end

    // One-hot expansion of the selected index.
    always_comb begin
        w_grant = '0;
        if (w_any_grant) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // A buffer that is being drained this cycle can take a new result at once.
    assign out_ready = ~r_full | w_grant;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unit
        assign w_in_tag[g] = in_tag[g*TAG_W +: TAG_W];
        assign w_in_val[g] = in_val[g*DATA_W +: DATA_W];
        // Offers tagged INVALID_TAG are handshaken but never stored.
        assign w_load[g]   = in_valid[g] & out_ready[g] & (w_in_tag[g] != INVALID_TAG);
    end

    // Per-unit buffer update: a load wins over a drain so grant+accept keeps full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_load[i]) begin
                    r_full[i] <= 1'b1;
                    r_tag[i]  <= w_in_tag[i];
                    r_val[i]  <= w_in_val[i];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Broadcast register: carries the granted buffer, idles at INVALID_TAG/0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_bcast <= 1'b0;
            r_cdb_tag   <= INVALID_TAG;
            r_cdb_val   <= '0;
        end else if (w_any_grant) begin
            r_cdb_bcast <= 1'b1;
            r_cdb_tag   <= r_tag[w_grant_idx];
            r_cdb_val   <= r_val[w_grant_idx];
        end else begin
            r_cdb_bcast <= 1'b0;
            r_cdb_tag   <= INVALID_TAG;
            r_cdb_val   <= '0;
        end
    end

`ifndef CDB_FIXED_PRIO_EN
    // Pointer moves to the slot just after the winner so it has lowest priority next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any_grant) begin
            r_ptr <= (w_grant_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end
`endif

    assign out_CDB_broadcast = r_cdb_bcast;
    assign out_CDB_tag       = r_cdb_tag;
    assign out_CDB_val       = r_cdb_val;
    assign out_pending       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. A transaction-level
//                reference model (per-unit slots plus a priority pointer)
//                predicts ready, broadcast and pending each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int         N   = 4;
    localparam int         TW  = 5;
    localparam int         DW  = 32;
    localparam logic [4:0] INV = 5'd31;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N*TW-1:0] in_tag = '0;
    logic [N*DW-1:0] in_val = '0;
    logic [N-1:0]    out_ready;
    logic            out_CDB_broadcast;
    logic [TW-1:0]   out_CDB_tag;
    logic [DW-1:0]   out_CDB_val;
    logic [N-1:0]    out_pending;

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .INVALID_TAG(INV)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .out_ready         (out_ready),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_pending       (out_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus for the next cycle.
    logic [N-1:0]  s_v;
    logic [TW-1:0] s_t [N];
    logic [DW-1:0] s_d [N];

    // Reference model state.
    bit            m_full [N];
    logic [TW-1:0] m_tag  [N];
    logic [DW-1:0] m_val  [N];
    int            m_ptr = 0;

    logic [N-1:0]  exp_ready, got_ready, exp_pend, got_pend;
    logic          exp_bc, got_bc;
    logic [TW-1:0] exp_tag, got_tag;
    logic [DW-1:0] exp_val, got_val;

    // Drive one cycle of stimulus, advance the model, capture DUT outputs.
    task automatic tick(input logic r);
        int g;
        logic [N-1:0] acc;
        rst = r;
        in_valid = s_v;
        for (int i = 0; i < N; i++) begin
            in_tag[i*TW +: TW] = s_t[i];
            in_val[i*DW +: DW] = s_d[i];
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
`ifdef CDB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_ptr + k) % N;
`endif
            if (g < 0 && m_full[idx]) g = idx;
        end
        for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i] || (g == i);
        acc = s_v & exp_ready;
        @(negedge clk);
        got_ready = out_ready;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ptr = 0;
            exp_bc = 1'b0; exp_tag = INV; exp_val = '0;
        end else begin
            if (g >= 0) begin
                exp_bc = 1'b1; exp_tag = m_tag[g]; exp_val = m_val[g];
                m_full[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end else begin
                exp_bc = 1'b0; exp_tag = INV; exp_val = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i] && s_t[i] != INV) begin
                    m_full[i] = 1'b1; m_tag[i] = s_t[i]; m_val[i] = s_d[i];
                end
            end
        end
        for (int i = 0; i < N; i++) exp_pend[i] = m_full[i];
        got_bc = out_CDB_broadcast; got_tag = out_CDB_tag;
        got_val = out_CDB_val; got_pend = out_pending;
    endtask

    task automatic idle_inputs();
        s_v = '0;
        for (int i = 0; i < N; i++) begin s_t[i] = '0; s_d[i] = '0; end
    endtask

    task automatic test_reset();
        idle_inputs();
        tick(1'b1); tick(1'b1);
        for (int c = 0; c < 4; c++) begin
            tick(1'b0);
            checks++;
            if (got_bc !== 1'b0 || got_tag !== 5'd31 || got_val !== 32'd0) begin
                errors++;
                $display("FAIL reset_bus c%0d got bc=%b tag=%0d val=%0h want 0/31/0", c, got_bc, got_tag, got_val);
            end
            checks++;
            if (got_ready !== 4'b1111 || got_pend !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready c%0d got ready=%b pend=%b want 1111/0000", c, got_ready, got_pend);
            end
        end
    endtask

    task automatic test_single();
        logic          e_bc  [3] = '{1'b0, 1'b1, 1'b0};
        logic [4:0]    e_tag [3] = '{5'd31, 5'd3, 5'd31};
        logic [31:0]   e_val [3] = '{32'd0, 32'h6, 32'd0};
        logic [3:0]    e_pnd [3] = '{4'b0100, 4'b0000, 4'b0000};
        idle_inputs();
        s_v = 4'b0100; s_t[2] = 5'd3; s_d[2] = 32'h6;
        for (int c = 0; c < 3; c++) begin
            tick(1'b0);
            idle_inputs();
            checks++;
            if (got_bc !== e_bc[c] || got_tag !== e_tag[c] || got_val !== e_val[c] || got_pend !== e_pnd[c]) begin
                errors++;
                $display("FAIL single c%0d got bc=%b tag=%0d val=%0h pend=%b want %b/%0d/%0h/%b",
                         c, got_bc, got_tag, got_val, got_pend, e_bc[c], e_tag[c], e_val[c], e_pnd[c]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] pair_tag [2] = '{5'd0, 5'd3};
        idle_inputs();
        tick(1'b1);
        for (int i = 0; i < N; i++) begin
            s_t[i] = 5'(i); s_d[i] = 32'(10 + i);
        end
        s_v = 4'b1111;
        tick(1'b0);
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            tick(1'b0);
            checks++;
            if (got_bc !== 1'b1 || got_tag !== 5'(k) || got_val !== 32'(10 + k)) begin
                errors++;
                $display("FAIL rr_order slot%0d got bc=%b tag=%0d val=%0d want 1/%0d/%0d", k, got_bc, got_tag, got_val, k, 10 + k);
            end
        end
        s_v = 4'b1001; s_t[0] = 5'd0; s_d[0] = 32'd20; s_t[3] = 5'd3; s_d[3] = 32'd23;
        tick(1'b0);
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            tick(1'b0);
            checks++;
            if (got_bc !== 1'b1 || got_tag !== pair_tag[k] || got_val !== 32'(20 + 3 * k)) begin
                errors++;
                $display("FAIL rr_pair slot%0d got tag=%0d val=%0d want %0d/%0d", k, got_tag, got_val, pair_tag[k], 20 + 3 * k);
            end
        end
`ifdef CDB_FIXED_PRIO_EN
        // Unit 0 keeps its buffer full every cycle; unit 3 must never win.
        s_v = 4'b1001; s_t[3] = 5'd3; s_d[3] = 32'd99;
        for (int c = 0; c < 6; c++) begin
            s_t[0] = 5'd1; s_d[0] = 32'(100 + c);
            tick(1'b0);
            checks++;
            if (got_tag === 5'd3 || (c > 0 && got_pend[3] !== 1'b1)) begin
                errors++;
                $display("FAIL fixed_block c%0d got tag=%0d pend=%b want unit3 blocked", c, got_tag, got_pend);
            end
        end
        idle_inputs();
        tick(1'b0); tick(1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                s_v = 4'b0010; s_t[1] = 5'd9; s_d[1] = 32'(c + 1);
            end else begin
                idle_inputs();
            end
            tick(1'b0);
            if (c < 8) begin
                checks++;
                if (got_ready[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready c%0d got %b want 1", c, got_ready[1]);
                end
            end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (got_bc !== 1'b1 || got_tag !== 5'd9 || got_val !== 32'(c)) begin
                    errors++;
                    $display("FAIL b2b_bcast c%0d got bc=%b tag=%0d val=%0d want 1/9/%0d", c, got_bc, got_tag, got_val, c);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] q0_t[$], q1_t[$];
        logic [DW-1:0] q0_d[$], q1_d[$];
        int prev_unit = -1;
        int unit;
        idle_inputs();
        for (int c = 0; c < 28; c++) begin
            if (c < 24) begin
                if (!s_v[0]) begin s_v[0] = 1'b1; s_t[0] = 5'($urandom_range(0, 14));  s_d[0] = $urandom; end
                if (!s_v[1]) begin s_v[1] = 1'b1; s_t[1] = 5'($urandom_range(16, 30)); s_d[1] = $urandom; end
            end
            tick(1'b0);
            if (s_v[0] && got_ready[0]) begin q0_t.push_back(s_t[0]); q0_d.push_back(s_d[0]); s_v[0] = 1'b0; end
            if (s_v[1] && got_ready[1]) begin q1_t.push_back(s_t[1]); q1_d.push_back(s_d[1]); s_v[1] = 1'b0; end
            checks++;
            if ({got_ready, got_bc, got_tag, got_val, got_pend} !== {exp_ready, exp_bc, exp_tag, exp_val, exp_pend}) begin
                errors++;
                $display("FAIL bp_model c%0d got rdy=%b bc=%b tag=%0d val=%0h pend=%b want %b/%b/%0d/%0h/%b",
                         c, got_ready, got_bc, got_tag, got_val, got_pend, exp_ready, exp_bc, exp_tag, exp_val, exp_pend);
            end
            if (c >= 1 && c < 24) begin
                checks++;
                if (got_ready[1:0] !== 2'b01 && got_ready[1:0] !== 2'b10) begin
                    errors++;
                    $display("FAIL bp_ready c%0d got %b want one-hot", c, got_ready[1:0]);
                end
            end
            if (got_bc === 1'b1) begin
                unit = (got_tag < 5'd16) ? 0 : 1;
                checks++;
                if ((unit == 0 && (q0_t.size() == 0 || q0_t[0] !== got_tag || q0_d[0] !== got_val)) ||
                    (unit == 1 && (q1_t.size() == 0 || q1_t[0] !== got_tag || q1_d[0] !== got_val))) begin
                    errors++;
                    $display("FAIL bp_data c%0d got tag=%0d val=%0h not the oldest held offer of unit %0d", c, got_tag, got_val, unit);
                end
                if (unit == 0 && q0_t.size() > 0) begin void'(q0_t.pop_front()); void'(q0_d.pop_front()); end
                if (unit == 1 && q1_t.size() > 0) begin void'(q1_t.pop_front()); void'(q1_d.pop_front()); end
                if (c >= 2 && c < 24) begin
                    checks++;
                    if (unit == prev_unit) begin
                        errors++;
                        $display("FAIL bp_alternate c%0d got unit %0d twice want alternation", c, unit);
                    end
                end
                prev_unit = unit;
            end
        end
        checks++;
        if (q0_t.size() != 0 || q1_t.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got %0d/%0d unbroadcast offers want 0/0", q0_t.size(), q1_t.size());
        end
    endtask

    task automatic test_invalid_and_reset();
        idle_inputs();
        s_v = 4'b0001; s_t[0] = INV; s_d[0] = 32'h5;
        for (int c = 0; c < 2; c++) begin
            tick(1'b0);
            idle_inputs();
            checks++;
            if (got_bc !== 1'b0 || got_pend !== 4'b0000) begin
                errors++;
                $display("FAIL invalid_tag c%0d got bc=%b pend=%b want 0/0000", c, got_bc, got_pend);
            end
        end
        s_v = 4'b1110;
        for (int i = 1; i < N; i++) begin s_t[i] = 5'(i + 4); s_d[i] = 32'(i * 7); end
        tick(1'b0);
        idle_inputs();
        checks++;
        if (got_pend !== 4'b1110) begin
            errors++;
            $display("FAIL fill_pend got %b want 1110", got_pend);
        end
        tick(1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick(1'b0);
            checks++;
            if (got_bc !== 1'b0 || got_tag !== INV || got_val !== 32'd0 || got_pend !== 4'b0000) begin
                errors++;
                $display("FAIL midrst c%0d got bc=%b tag=%0d val=%0h pend=%b want 0/31/0/0000", c, got_bc, got_tag, got_val, got_pend);
            end
        end
    endtask

    task automatic test_random();
        logic r;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_v[i] && ($urandom_range(0, 1) == 1)) begin
                    s_v[i] = 1'b1;
                    s_t[i] = ($urandom_range(0, 7) == 0) ? INV : 5'($urandom_range(0, 30));
                    s_d[i] = $urandom;
                end
            end
            r = ($urandom_range(0, 59) == 0);
            tick(r);
            checks++;
            if ({got_ready, got_bc, got_tag, got_val, got_pend} !== {exp_ready, exp_bc, exp_tag, exp_val, exp_pend}) begin
                errors++;
                $display("FAIL rand_model c%0d got rdy=%b bc=%b tag=%0d val=%0h pend=%b want %b/%b/%0d/%0h/%b",
                         c, got_ready, got_bc, got_tag, got_val, got_pend, exp_ready, exp_bc, exp_tag, exp_val, exp_pend);
            end
            for (int i = 0; i < N; i++) begin
                if (s_v[i] && got_ready[i]) s_v[i] = 1'b0;
            end
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) tick(1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_tag[i] = '0; m_val[i] = '0; end
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_invalid_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the Tomasulo core. It accepts completed results (tag, value) from up to N functional units, buffers one result per unit, and grants the single CDB to one unit per cycle. The granted result goes out on the registered broadcast outputs consumed by the register status table and the reservation stations.

## Interface
- N_REQ, 4: number of requesting functional units (2..8).
- TAG_W, 5: tag width.
- DATA_W, 32: result value width.
- INVALID_TAG, 5'b11111: tag meaning "no producer"; driven on the bus when idle.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  N_REQ  unit i offers a result this cycle.
- in_tag  in  N_REQ*TAG_W  tag of unit i in bits [i*TAG_W +: TAG_W].
- in_val  in  N_REQ*DATA_W  value of unit i in bits [i*DATA_W +: DATA_W].
- out_ready  out  N_REQ  unit i's offer is accepted this cycle when in_valid[i] & out_ready[i].
- out_CDB_broadcast  out  1  registered; high for exactly one cycle per broadcast result.
- out_CDB_tag  out  TAG_W  registered broadcast tag.
- out_CDB_val  out  DATA_W  registered broadcast value.
- out_pending  out  N_REQ  registered; buffer i currently holds an unbroadcast result.

## Operation
- Per-unit one-entry buffer {full, tag, val}. `out_pending` is the vector of `full` bits.
- Grant vector `grant` is combinational. It is computed only from `full` and the priority pointer `ptr`, never from `in_valid`, so no combinational loop exists. It is one-hot or zero.
- Round-robin search: scan indices ptr, ptr+1, … modulo N_REQ. The first full buffer wins.
- `out_ready[i] = ~full[i] | grant[i]`. A buffer being drained may accept a new result in the same cycle.
- On each edge, per buffer:
  - accept without grant: load tag/val, set full.
  - grant without accept: clear full.
  - grant with accept: load the new tag/val, full stays 1.
  - neither: hold.
- On each edge, bus registers:
  - if any grant: `out_CDB_broadcast`=1, `out_CDB_tag`/`out_CDB_val` take the granted buffer's contents, and ptr becomes (granted index + 1) mod N_REQ.
  - otherwise: broadcast=0, tag=INVALID_TAG, val=0, ptr unchanged.
- An offer carrying tag INVALID_TAG is accepted (ready follows normal rules) but discarded: full is not set and nothing is broadcast.
- No state machine beyond the buffers and ptr. The arbiter is fully pipelined with one broadcast per cycle maximum.

## Timing
- Reset values: `out_CDB_broadcast`=0, `out_CDB_tag`=INVALID_TAG, `out_CDB_val`=0, `out_pending`=0, ptr=0. `out_ready` is therefore all-ones in the cycle after reset.
- Reset asserted mid-operation discards all buffered results; nothing is broadcast for them.
- Latency: an offer accepted at edge E is broadcast-visible after edge E+1 at the earliest. That is 2 cycles from offer to visible broadcast.
- Sustained single requester: one broadcast per cycle.
- With k full buffers contending, each is granted within k cycles. No starvation.
- An offer not accepted must be held stable by the unit until `out_ready[i]` is high.

## Configuration
- `CDB_FIXED_PRIO_EN` undefined: round-robin arbitration as above.
- `CDB_FIXED_PRIO_EN` defined: the lowest-index full buffer always wins. ptr is not implemented and its reset/update rules do not apply. Starvation of high indices is permitted.

## Test plan
- Reset, idle:
  - Apply rst for 2 cycles, then keep in_valid=0.
  - Required: broadcast=0, tag=31, val=0 and out_ready=4'b1111 every cycle.
- Single result:
  - Offer unit 2, tag=3, val=32'h6 for one cycle.
  - Required: broadcast high exactly 2 cycles later for one cycle, carrying tag 3 / 6. `out_pending[2]` is high only in between.
- Round-robin contention:
  - All four units offer together (tags 0..3, vals 10..13) with ptr=0.
  - Required: broadcasts on 4 consecutive cycles in order 0, 1, 2, 3.
  - Then offer units 0 and 3 together: order is 0 then 3.
  - With `CDB_FIXED_PRIO_EN`, the second pair still gives 0 then 3, and a continuous unit 0 stream blocks unit 3.
- Back-to-back throughput:
  - Unit 1 offers a new result every cycle for 8 cycles (vals 1..8).
  - Required: out_ready[1] stays high and 8 consecutive broadcasts carry vals 1..8.
- Backpressure:
  - Units 0 and 1 stream continuously.
  - Required: broadcasts alternate 0/1. Each unit sees out_ready low every other cycle. Every held offer is broadcast exactly once with unchanged tag/val.
- Invalid tag and mid-run reset:
  - Offer tag=31 on unit 0. Required: no broadcast and `out_pending` stays 0.
  - Fill buffers 1–3, then assert rst for one cycle. Required: no broadcast afterward, outputs at reset values.
